fft_twiddle_sequencer: RTL and testbench

Butterfly/twiddle scheduler for the 32-point radix-2 DIT FFT. Once started, it walks the 5 stages × 16 butterflies in order. For each butterfly it presents the top/bottom data-memory addresses and the 4-bit twiddle index that selects one of the 16 twiddle ROM registers (real and imaginary, index 0..15). It sits between the top-level control and the butterfly datapath, with a valid/ready handshake toward the datapath.

---
 rtl/fft_twiddle_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer.sv
// Butterfly/twiddle scheduler for a 32-point radix-2 DIT FFT.
// Walks 5 stages x 16 butterflies, presenting addresses and twiddle index over a valid/ready handshake.
module fft_twiddle_sequencer #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bf_ready,
    output logic       bf_valid,
    output logic [4:0] addr_top,
    output logic [4:0] addr_bot,
    output logic [3:0] tw_idx,
    output logic [2:0] stage,
    output logic       last_in_stage,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_t;

    localparam logic [2:0] GAP_LAST = (GAP_CYCLES == 0) ? 3'd0 : 3'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] s, s_n;
    logic [3:0] b, b_n;
    logic [2:0] g, g_n;

    logic       bf_valid_n;
    logic [4:0] addr_top_n;
    logic [4:0] addr_bot_n;
    logic [3:0] tw_idx_n;
    logic [2:0] stage_n;
    logic       last_n;
    logic       busy_n;
    logic       done_n;
    logic       load;

    // Upper input: insert a zero at bit position st of b, i.e. ((b >> st) << (st+1)) | (b mod 2^st).
    function automatic logic [4:0] top_of(input logic [2:0] st, input logic [3:0] bi);
        logic [4:0] wide;
        logic [4:0] mask;
        wide = {1'b0, bi};
        mask = (5'd1 << st) - 5'd1;
        return ((wide & ~mask) << 1) | (wide & mask);
    endfunction

    function automatic logic [3:0] tw_of(input logic [2:0] st, input logic [3:0] bi);
        logic [4:0] j;
        logic [4:0] shifted;
        j       = {1'b0, bi} & ((5'd1 << st) - 5'd1);
        shifted = j << (3'd4 - st);
        return shifted[3:0];
    endfunction

    always_comb begin
        state_n    = state;
        s_n        = s;
        b_n        = b;
        g_n        = g;
        bf_valid_n = bf_valid;
        addr_top_n = addr_top;
        addr_bot_n = addr_bot;
        tw_idx_n   = tw_idx;
        stage_n    = stage;
        last_n     = last_in_stage;
        busy_n     = busy;
        done_n     = 1'b0;
        load       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    s_n     = 3'd0;
                    b_n     = 4'd0;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (bf_ready) begin
                    if (b != 4'd15) begin
                        b_n  = b + 4'd1;
                        load = 1'b1;
                    end else if (s != 3'd4) begin
                        if (GAP_CYCLES == 0) begin
                            s_n  = s + 3'd1;
                            b_n  = 4'd0;
                            load = 1'b1;
                        end else begin
                            state_n    = GAP;
                            g_n        = 3'd0;
                            bf_valid_n = 1'b0;
                            last_n     = 1'b0;
                        end
                    end else begin
                        state_n    = DONE;
                        bf_valid_n = 1'b0;
                        last_n     = 1'b0;
                        done_n     = 1'b1;
                    end
                end
            end
            GAP: begin
                if (g == GAP_LAST) begin
                    state_n = RUN;
                    s_n     = s + 3'd1;
                    b_n     = 4'd0;
                    load    = 1'b1;
                end else begin
                    g_n = g + 3'd1;
                end
            end
            DONE: begin
                // Returning to IDLE restores every output and counter to its reset value.
                state_n    = IDLE;
                s_n        = 3'd0;
                b_n        = 4'd0;
                g_n        = 3'd0;
                bf_valid_n = 1'b0;
                addr_top_n = '0;
                addr_bot_n = '0;
                tw_idx_n   = '0;
                stage_n    = '0;
                last_n     = 1'b0;
                busy_n     = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            bf_valid_n = 1'b1;
            addr_top_n = top_of(s_n, b_n);
            addr_bot_n = top_of(s_n, b_n) + (5'd1 << s_n);
            tw_idx_n   = tw_of(s_n, b_n);
            stage_n    = s_n;
            last_n     = (b_n == 4'd15);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            s             <= '0;
            b             <= '0;
            g             <= '0;
            bf_valid      <= 1'b0;
            addr_top      <= '0;
            addr_bot      <= '0;
            tw_idx        <= '0;
            stage         <= '0;
            last_in_stage <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            s             <= s_n;
            b             <= b_n;
            g             <= g_n;
            bf_valid      <= bf_valid_n;
            addr_top      <= addr_top_n;
            addr_bot      <= addr_bot_n;
            tw_idx        <= tw_idx_n;
            stage         <= stage_n;
            last_in_stage <= last_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Scoreboard bench for fft_twiddle_sequencer: one instance with a 2-cycle stage gap, one with none.
module tb_fft_twiddle_sequencer;

    localparam int unsigned GAP_A = 2;
    localparam int unsigned GAP_B = 0;

    typedef struct {
        int s;
        int b;
        int top;
        int bot;
        int tw;
    } bfly_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start;
    logic [1:0]      bf_ready;
    logic [1:0]      bf_valid;
    logic [1:0][4:0] addr_top;
    logic [1:0][4:0] addr_bot;
    logic [1:0][3:0] tw_idx;
    logic [1:0][2:0] stage;
    logic [1:0]      last_in_stage;
    logic [1:0]      busy;
    logic [1:0]      done;

    int passed = 0;
    int total  = 0;
    int edge_cnt = 0;

    bfly_t exp_q [2][$];
    int    n0     [2];
    int    stalls [2];
    int    xfers  [2];
    int    gaplen [2];
    bit    active [2];
    bit    after_done [2];
    bit    fresh  [2];
    bit    rst_prev = 1'b0;

    fft_twiddle_sequencer #(.GAP_CYCLES(GAP_A)) dut (
        .clk(clk), .rst(rst), .start(start[0]), .bf_ready(bf_ready[0]),
        .bf_valid(bf_valid[0]), .addr_top(addr_top[0]), .addr_bot(addr_bot[0]),
        .tw_idx(tw_idx[0]), .stage(stage[0]), .last_in_stage(last_in_stage[0]),
        .busy(busy[0]), .done(done[0])
    );

    fft_twiddle_sequencer #(.GAP_CYCLES(GAP_B)) dut_nogap (
        .clk(clk), .rst(rst), .start(start[1]), .bf_ready(bf_ready[1]),
        .bf_valid(bf_valid[1]), .addr_top(addr_top[1]), .addr_bot(addr_bot[1]),
        .tw_idx(tw_idx[1]), .stage(stage[1]), .last_in_stage(last_in_stage[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int gap_of(input int i);
        return (i == 0) ? int'(GAP_A) : int'(GAP_B);
    endfunction

    // Reference: in stage s the b-th butterfly pairs the b-th index (ascending) whose bit s is clear
    // with its partner 2^s above; twiddle exponent is that index mod 2^s scaled to a 32-point circle.
    function automatic bfly_t ref_bfly(input int s, input int b);
        bfly_t r;
        int    n;
        n = 0;
        r.s = s;
        r.b = b;
        r.top = 0;
        for (int x = 0; x < 32; x++) begin
            if (((x >> s) & 1) == 0) begin
                if (n == b) r.top = x;
                n++;
            end
        end
        r.bot = r.top + (1 << s);
        r.tw  = ((r.top % (1 << s)) * (16 >> s)) % 16;
        return r;
    endfunction

    task automatic check(input int i, input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL inst%0d %s: got %0d expected %0d at t=%0t", i, name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        bfly_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst_prev) begin
                check(i, "reset_outputs",
                      int'({bf_valid[i], addr_top[i], addr_bot[i], tw_idx[i], stage[i],
                            last_in_stage[i], busy[i], done[i]}), 0);
            end else if (active[i]) begin
                check(i, "busy_high", int'(busy[i]), 1);
                if (bf_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check(i, "unexpected_bfly", int'(bf_valid[i]), 0);
                    end else begin
                        e = exp_q[i][0];
                        if (fresh[i]) begin
                            if (e.b == 0 && e.s > 0) check(i, "gap_len", gaplen[i], gap_of(i));
                            gaplen[i] = 0;
                            fresh[i]  = 1'b0;
                        end
                        check(i, "stage",    int'(stage[i]),    e.s);
                        check(i, "addr_top", int'(addr_top[i]), e.top);
                        check(i, "addr_bot", int'(addr_bot[i]), e.bot);
                        check(i, "tw_idx",   int'(tw_idx[i]),   e.tw);
                        check(i, "last_in_stage", int'(last_in_stage[i]), (e.b == 15) ? 1 : 0);
                        if (bf_ready[i]) begin
                            void'(exp_q[i].pop_front());
                            xfers[i]++;
                            fresh[i] = 1'b1;
                        end else begin
                            stalls[i]++;
                        end
                    end
                end else if (!done[i]) begin
                    gaplen[i]++;
                end
                if (done[i]) begin
                    check(i, "done_cycle", edge_cnt - n0[i], 80 + 4 * gap_of(i) + stalls[i]);
                    check(i, "transfers", xfers[i], 80);
                    check(i, "queue_empty", exp_q[i].size(), 0);
                    active[i]     = 1'b0;
                    after_done[i] = 1'b1;
                end
            end else if (after_done[i]) begin
                check(i, "after_done_idle", int'({busy[i], done[i], bf_valid[i]}), 0);
                after_done[i] = 1'b0;
            end else begin
                check(i, "idle_quiet", int'({busy[i], done[i], bf_valid[i]}), 0);
            end

            if (!rst && !rst_prev && start[i] && !busy[i] && !active[i]) begin
                n0[i]     = edge_cnt + 1;
                stalls[i] = 0;
                xfers[i]  = 0;
                gaplen[i] = 0;
                fresh[i]  = 1'b1;
                active[i] = 1'b1;
                for (int s = 0; s < 5; s++)
                    for (int b = 0; b < 16; b++)
                        exp_q[i].push_back(ref_bfly(s, b));
            end

            if (rst) begin
                exp_q[i].delete();
                active[i]     = 1'b0;
                after_done[i] = 1'b0;
            end
        end
        rst_prev = rst;
    end

    task automatic do_run(input int i, input bit rnd, input bit stall17, input bit poke, input bit abort23);
        int stalled;
        bit finished;
        stalled  = 0;
        finished = 1'b0;
        @(posedge clk); #1;
        start[i]    = 1'b1;
        bf_ready[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            start[i]    = 1'b0;
            bf_ready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall17 && bf_valid[i] && stage[i] == 3'd1 && addr_top[i] == 5'd13 && stalled < 3) begin
                bf_ready[i] = 1'b0;
                stalled++;
            end
            if (poke && bf_valid[i] && stage[i] == 3'd3 && addr_top[i] == 5'd0) start[i] = 1'b1;
            if (done[i]) begin
                start[i] = poke;
                finished = 1'b1;
            end
            if (abort23 && bf_valid[i] && stage[i] == 3'd2 && addr_top[i] == 5'd3) begin
                rst      = 1'b1;
                finished = 1'b1;
            end
            @(posedge clk); #1;
        end
        start[i]    = 1'b0;
        bf_ready[i] = 1'b0;
        rst         = 1'b0;
        check(i, "run_completed", int'(finished), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = '0;
        bf_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_run(0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_run(0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_run(0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_run(0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_run(0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_run(1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_run(1, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
